// File: rtl/lane_speed_ctrl_if.sv
// -----------------------------------------------------------------------------
// lane_speed_ctrl_if
// Groups the game-event inputs and the status outputs of lane_speed_ctrl.
//   start      : begin / restart the game
//   pause      : level-sensitive pause request
//   frog_hit   : one-frame pulse, frog collided with a car
//   frog_home  : one-frame pulse, frog reached the goal row
//   lane_step  : per-lane one-frame move enables (bit i -> lane i)
//   level      : current difficulty level
//   lives      : remaining lives
//   state      : controller state (IDLE=0 RUN=1 PAUSED=2 HIT_FREEZE=3
//                LEVEL_UP=4 GAME_OVER=5)
// master drives the events (game logic / bench), slave is the controller.
// -----------------------------------------------------------------------------
interface lane_speed_ctrl_if;
    logic       start;
    logic       pause;
    logic       frog_hit;
    logic       frog_home;
    logic [3:0] lane_step;
    logic [2:0] level;
    logic [1:0] lives;
    logic [2:0] state;

    modport master (
        output start, pause, frog_hit, frog_home,
        input  lane_step, level, lives, state
    );

    modport slave (
        input  start, pause, frog_hit, frog_home,
        output lane_step, level, lives, state
    );
endinterface

// File: rtl/lane_speed_ctrl.sv
// -----------------------------------------------------------------------------
// lane_speed_ctrl
// Game-flow controller for a four-lane traffic game. Generates per-lane pixel
// step enables whose rate rises with the difficulty level, and tracks lives,
// level and freeze periods after a hit or a level-up.
// Ports:
//   frame_clk : frame clock, all state changes on its rising edge
//   Reset     : asynchronous, active-high reset
//   bus       : lane_speed_ctrl_if.slave (start, pause, frog_hit, frog_home in;
//               lane_step, level, lives, state out)
// -----------------------------------------------------------------------------
module lane_speed_ctrl #(
    parameter logic [3:0] LANE0_BASE   = 4'd4,
    parameter logic [3:0] LANE1_BASE   = 4'd3,
    parameter logic [3:0] LANE2_BASE   = 4'd2,
    parameter logic [3:0] LANE3_BASE   = 4'd5,
    parameter logic [2:0] MAX_LEVEL    = 3'd7,
    parameter int         HIT_FRAMES   = 60,
    parameter int         LEVEL_FRAMES = 30
) (
    input  logic              frame_clk,
    input  logic              Reset,
    lane_speed_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RUN        = 3'd1,
        S_PAUSED     = 3'd2,
        S_HIT_FREEZE = 3'd3,
        S_LEVEL_UP   = 3'd4,
        S_GAME_OVER  = 3'd5
    } state_t;

    localparam int TMR_MAX = (HIT_FRAMES > LEVEL_FRAMES) ? HIT_FRAMES : LEVEL_FRAMES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] HIT_LOAD   = TMR_W'(HIT_FRAMES - 1);
    localparam logic [TMR_W-1:0] LEVEL_LOAD = TMR_W'(LEVEL_FRAMES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

    localparam logic [3:0][3:0] LANE_BASE = {LANE3_BASE, LANE2_BASE, LANE1_BASE, LANE0_BASE};

    // Lane period shrinks with level but never below one frame; the compare
    // keeps the subtraction from underflowing in 4 bits.
    function automatic logic [3:0] lane_period(input logic [3:0] base, input logic [2:0] lvl);
        logic [3:0] lvl4;
        lvl4 = {1'b0, lvl};
        if (base > lvl4) begin
            return base - lvl4;
        end
        return 4'd1;
    endfunction

    function automatic logic [2:0] level_inc(input logic [2:0] lvl);
        if (lvl >= MAX_LEVEL) begin
            return MAX_LEVEL;
        end
        return lvl + 3'd1;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       level_q, level_d;
    logic [1:0]       lives_q, lives_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [3:0][3:0]  cnt_q, cnt_d;
    logic [3:0]       lane_step_q, lane_step_d;
    logic [3:0][3:0]  period;
    logic [3:0]       fire;

    always_comb begin
        period = '0;
        for (int i = 0; i < 4; i++) begin
            period[i] = lane_period(LANE_BASE[i], level_q);
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            level_q     <= 3'd0;
            lives_q     <= 2'd3;
            timer_q     <= '0;
            cnt_q       <= '0;
            lane_step_q <= 4'b0000;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            lives_q     <= lives_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            lane_step_q <= lane_step_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        lives_d     = lives_q;
        timer_d     = timer_q;
        cnt_d       = cnt_q;
        lane_step_d = 4'b0000;
        fire        = 4'b0000;

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    lives_d = 2'd3;
                    level_d = 3'd0;
                    timer_d = '0;
                    cnt_d   = '0;
                end
            end

            S_RUN: begin
                // '>=' rather than '==' so a counter left above a freshly
                // shortened period fires next frame instead of wrapping.
                for (int i = 0; i < 4; i++) begin
                    if (cnt_q[i] >= (period[i] - 4'd1)) begin
                        cnt_d[i] = 4'd0;
                        fire[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    end
                end

                if (bus.frog_hit) begin
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                        timer_d = HIT_LOAD;
                        state_d = S_HIT_FREEZE;
                    end else begin
                        lives_d = 2'd0;
                        state_d = S_GAME_OVER;
                    end
                end else if (bus.frog_home) begin
                    level_d = level_inc(level_q);
                    timer_d = LEVEL_LOAD;
                    state_d = S_LEVEL_UP;
                end else if (bus.pause) begin
                    state_d = S_PAUSED;
                end

                // A step registered on the frame that leaves RUN would show up
                // while the lanes are supposed to be frozen, so drop it.
                if (state_d == S_RUN) begin
                    lane_step_d = fire;
                end
            end

            S_PAUSED: begin
                if (!bus.pause) begin
                    state_d = S_RUN;
                end
            end

            S_HIT_FREEZE, S_LEVEL_UP: begin
                // Timer loaded with N-1 and RUN resumes on the frame it reads
                // zero, giving exactly N frozen frames.
                if (timer_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.lane_step = lane_step_q;
    assign bus.level     = level_q;
    assign bus.lives     = lives_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_lane_speed_ctrl.sv
module tb_lane_speed_ctrl;

    localparam int HIT_FRAMES   = 60;
    localparam int LEVEL_FRAMES = 30;
    localparam int MAX_LEVEL    = 7;
    localparam int BASE [4]     = '{4, 3, 2, 5};

    logic frame_clk = 1'b0;
    logic Reset     = 1'b0;

    lane_speed_ctrl_if bus ();

    lane_speed_ctrl #(
        .LANE0_BASE   (4'd4),
        .LANE1_BASE   (4'd3),
        .LANE2_BASE   (4'd2),
        .LANE3_BASE   (4'd5),
        .MAX_LEVEL    (3'd7),
        .HIT_FRAMES   (HIT_FRAMES),
        .LEVEL_FRAMES (LEVEL_FRAMES)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Game model: state as a small integer, lanes tracked as "frames
    // elapsed since the lane last moved", freezes as frames remaining.
    // ------------------------------------------------------------------
    int         m_state  = 0;
    int         m_lives  = 3;
    int         m_level  = 0;
    int         m_freeze = 0;
    int         m_phase [4] = '{0, 0, 0, 0};
    logic [3:0] m_step   = 4'b0000;

    always @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            m_state  = 0;
            m_lives  = 3;
            m_level  = 0;
            m_freeze = 0;
            m_step   = 4'b0000;
            for (int i = 0; i < 4; i++) m_phase[i] = 0;
        end else begin : model_step
            logic [3:0] due;
            int         nxt;
            int         per;
            due = 4'b0000;
            nxt = m_state;
            case (m_state)
                0, 5: begin
                    if (bus.start) begin
                        nxt     = 1;
                        m_lives = 3;
                        m_level = 0;
                        for (int i = 0; i < 4; i++) m_phase[i] = 0;
                    end
                end
                1: begin
                    for (int i = 0; i < 4; i++) begin
                        per = BASE[i] - m_level;
                        if (per < 1) per = 1;
                        m_phase[i] = m_phase[i] + 1;
                        if (m_phase[i] >= per) begin
                            m_phase[i] = 0;
                            due[i]     = 1'b1;
                        end
                    end
                    if (bus.frog_hit) begin
                        if (m_lives > 1) begin
                            m_lives  = m_lives - 1;
                            m_freeze = HIT_FRAMES;
                            nxt      = 3;
                        end else begin
                            m_lives = 0;
                            nxt     = 5;
                        end
                    end else if (bus.frog_home) begin
                        m_level  = (m_level < MAX_LEVEL) ? m_level + 1 : MAX_LEVEL;
                        m_freeze = LEVEL_FRAMES;
                        nxt      = 4;
                    end else if (bus.pause) begin
                        nxt = 2;
                    end
                end
                2: begin
                    if (!bus.pause) nxt = 1;
                end
                3, 4: begin
                    m_freeze = m_freeze - 1;
                    if (m_freeze == 0) nxt = 1;
                end
                default: nxt = 0;
            endcase
            m_step  = (m_state == 1 && nxt == 1) ? due : 4'b0000;
            m_state = nxt;
        end
    end

    always @(negedge frame_clk) begin
        check("model_state", int'(bus.state), m_state);
        check("model_lives", int'(bus.lives), m_lives);
        check("model_level", int'(bus.level), m_level);
        check("model_lane_step", int'(bus.lane_step), int'(m_step));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) @(negedge frame_clk);
    endtask

    task automatic pulse_hit();
        bus.frog_hit = 1'b1;
        @(negedge frame_clk);
        bus.frog_hit = 1'b0;
    endtask

    task automatic pulse_home();
        bus.frog_home = 1'b1;
        @(negedge frame_clk);
        bus.frog_home = 1'b0;
    endtask

    initial begin : stim
        int first [4];
        int cnt   [4];
        int n;
        int zeros_ok;

        bus.start     = 1'b0;
        bus.pause     = 1'b0;
        bus.frog_hit  = 1'b0;
        bus.frog_home = 1'b0;

        #1 Reset = 1'b1;
        frames(2);
        check("reset_state", int'(bus.state), 0);
        check("reset_lives", int'(bus.lives), 3);
        check("reset_level", int'(bus.level), 0);
        check("reset_lane_step", int'(bus.lane_step), 0);
        Reset = 1'b0;
        frames(2);
        check("idle_no_start", int'(bus.state), 0);

        // Level-0 lane cadence over 20 frames.
        bus.start = 1'b1;
        @(negedge frame_clk);
        bus.start = 1'b0;
        check("start_state", int'(bus.state), 1);
        check("start_lives", int'(bus.lives), 3);
        for (int i = 0; i < 4; i++) begin
            first[i] = -1;
            cnt[i]   = 0;
        end
        for (int f = 1; f <= 20; f++) begin
            @(negedge frame_clk);
            for (int i = 0; i < 4; i++) begin
                if (bus.lane_step[i]) begin
                    cnt[i]++;
                    if (first[i] < 0) first[i] = f;
                end
            end
        end
        check("first_pulse_lane0", first[0], 4);
        check("first_pulse_lane1", first[1], 3);
        check("first_pulse_lane2", first[2], 2);
        check("first_pulse_lane3", first[3], 5);
        check("pulses_lane0", cnt[0], 5);
        check("pulses_lane1", cnt[1], 6);
        check("pulses_lane2", cnt[2], 10);
        check("pulses_lane3", cnt[3], 4);

        // Pause with lane-0 counter at 2: count resumes, fires on 2nd RUN frame.
        frames(2);
        bus.pause = 1'b1;
        zeros_ok  = 1;
        for (int f = 0; f < 10; f++) begin
            @(negedge frame_clk);
            if (bus.lane_step != 4'b0000 || bus.state != 3'd2) zeros_ok = 0;
        end
        check("pause_quiet", zeros_ok, 1);
        bus.pause = 1'b0;
        @(negedge frame_clk);
        check("unpause_state", int'(bus.state), 1);
        check("unpause_run1_lane0", int'(bus.lane_step[0]), 0);
        @(negedge frame_clk);
        check("unpause_run2_lane0", int'(bus.lane_step[0]), 1);

        // Hit and home together: hit wins, 60 frozen frames, inputs ignored.
        bus.frog_hit  = 1'b1;
        bus.frog_home = 1'b1;
        @(negedge frame_clk);
        bus.frog_hit  = 1'b0;
        bus.frog_home = 1'b0;
        check("hit_prio_state", int'(bus.state), 3);
        check("hit_prio_lives", int'(bus.lives), 2);
        check("hit_prio_level", int'(bus.level), 0);
        n        = 0;
        zeros_ok = 1;
        while (bus.state == 3'd3 && n < 100) begin
            if (bus.lane_step != 4'b0000) zeros_ok = 0;
            if (n == 10) begin
                bus.frog_home = 1'b1;
                bus.start     = 1'b1;
                bus.pause     = 1'b1;
            end else begin
                bus.frog_home = 1'b0;
                bus.start     = 1'b0;
                bus.pause     = 1'b0;
            end
            n++;
            @(negedge frame_clk);
        end
        bus.frog_home = 1'b0;
        bus.start     = 1'b0;
        bus.pause     = 1'b0;
        check("hit_freeze_len", n, 60);
        check("hit_freeze_quiet", zeros_ok, 1);
        check("hit_freeze_exit", int'(bus.state), 1);

        // Seven level-ups reach MAX, an eighth saturates, lanes clamp to 1.
        for (int k = 1; k <= 8; k++) begin
            pulse_home();
            check("levelup_state", int'(bus.state), 4);
            frames(LEVEL_FRAMES);
            check("levelup_exit", int'(bus.state), 1);
            check("levelup_level", int'(bus.level), (k < 7) ? k : 7);
        end
        for (int f = 0; f < 4; f++) begin
            @(negedge frame_clk);
            check("max_level_all_lanes", int'(bus.lane_step), 15);
        end

        // Asynchronous reset in the middle of a hit freeze (timer = 25).
        pulse_hit();
        check("pre_reset_state", int'(bus.state), 3);
        frames(34);
        #2 Reset = 1'b1;
        #1;
        check("async_reset_state", int'(bus.state), 0);
        check("async_reset_lives", int'(bus.lives), 3);
        check("async_reset_level", int'(bus.level), 0);
        check("async_reset_lane_step", int'(bus.lane_step), 0);
        frames(2);
        Reset = 1'b0;
        bus.frog_hit  = 1'b1;
        bus.pause     = 1'b1;
        @(negedge frame_clk);
        bus.frog_hit  = 1'b0;
        bus.frog_home = 1'b1;
        @(negedge frame_clk);
        bus.frog_home = 1'b0;
        bus.pause     = 1'b0;
        for (int f = 0; f < 4; f++) begin
            @(negedge frame_clk);
            check("post_reset_idle", int'(bus.state), 0);
            check("post_reset_quiet", int'(bus.lane_step), 0);
        end

        // Three hits to GAME_OVER, then restart.
        bus.start = 1'b1;
        @(negedge frame_clk);
        bus.start = 1'b0;
        check("restart_lives", int'(bus.lives), 3);
        pulse_home();
        frames(LEVEL_FRAMES);
        check("pre_gameover_level", int'(bus.level), 1);
        for (int k = 0; k < 3; k++) begin
            pulse_hit();
            check("hit_seq_lives", int'(bus.lives), 2 - k);
            if (k < 2) begin
                check("hit_seq_state", int'(bus.state), 3);
                frames(HIT_FRAMES);
                check("hit_seq_exit", int'(bus.state), 1);
            end else begin
                check("gameover_state", int'(bus.state), 5);
            end
        end
        pulse_home();
        check("gameover_ignores_home", int'(bus.state), 5);
        bus.start = 1'b1;
        @(negedge frame_clk);
        bus.start = 1'b0;
        check("gameover_restart_state", int'(bus.state), 1);
        check("gameover_restart_lives", int'(bus.lives), 3);
        check("gameover_restart_level", int'(bus.level), 0);
        frames(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
